// File: rtl/t_flipflop.sv
// Bank of WIDTH independent T flip-flops with asynchronous active-high reset.
// q is the registered state; q_bar is its complement with no added delay.
module t_flipflop #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: each set bit of t flips the corresponding stored bit.
  always_comb begin
    q_d = q_q ^ t;
  end

  // State register; reset wins over a coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // q_bar is derived from the same register so it can never lag q.
  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: tb/tb_t_flipflop.sv
// Directed bench for t_flipflop: a 1-bit and a 4-bit instance driven side by side,
// checked each cycle against a per-bit toggle model plus literal expectations.
module tb_t_flipflop;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t1  = 1'b0;
  logic [3:0] t4  = 4'b0000;
  logic       q1, qb1;
  logic [3:0] q4, qb4;

  int vectors    = 0;
  int miscompares = 0;

  logic       m1;
  logic [3:0] m4;
  bit         model_valid = 1'b0;

  localparam logic [3:0] RV4 = 4'b1010;

  always #5 clk = ~clk;

  t_flipflop #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .t(t1), .q(q1), .q_bar(qb1)
  );

  t_flipflop #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (
    .clk(clk), .rst(rst), .t(t4), .q(q4), .q_bar(qb4)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: reset loads the reset value, otherwise each enabled bit flips.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= 1'b0;
      m4 <= RV4;
      if (clk) model_valid <= 1'b1;
    end else begin
      m1 <= t1 ? !m1 : m1;
      for (int i = 0; i < 4; i++) begin
        m4[i] <= t4[i] ? !m4[i] : m4[i];
      end
    end
  end

  // Cycle compare against the model on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_q1",  {3'b000, q1},  {3'b000, m1});
      check("model_qb1", {3'b000, qb1}, {3'b000, !m1});
      check("model_q4",  q4,  m4);
      check("model_qb4", qb4, ~m4);
    end
  end

  initial begin
    // Reset held across two edges.
    repeat (2) @(negedge clk);
    check("rst_q1",  {3'b000, q1},  4'b0000);
    check("rst_qb1", {3'b000, qb1}, 4'b0001);
    check("rst_q4",  q4,  4'b1010);
    check("rst_qb4", qb4, 4'b0101);
    rst = 1'b0;

    // Hold on 1-bit, vector toggle on 4-bit.
    t1 = 1'b0; t4 = 4'b0110;
    @(negedge clk);
    check("hold_q1",  {3'b000, q1},  4'b0000);
    check("hold_qb1", {3'b000, qb1}, 4'b0001);
    check("vec_q4",   q4,  4'b1100);
    check("vec_qb4",  qb4, 4'b0011);

    // Toggle twice.
    t1 = 1'b1; t4 = 4'b1111;
    @(negedge clk);
    check("tog1_q1",  {3'b000, q1},  4'b0001);
    check("tog1_qb1", {3'b000, qb1}, 4'b0000);
    check("all_q4",   q4,  4'b0011);
    t4 = 4'b0001;
    @(negedge clk);
    check("tog2_q1",  {3'b000, q1},  4'b0000);
    check("tog2_qb1", {3'b000, qb1}, 4'b0001);
    check("lsb_q4",   q4,  4'b0010);

    // Back to 1, then hold for two edges.
    t4 = 4'b0000;
    @(negedge clk);
    check("set_q1", {3'b000, q1}, 4'b0001);
    t1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("hold2_q1",  {3'b000, q1},  4'b0001);
      check("hold2_qb1", {3'b000, qb1}, 4'b0000);
      check("hold2_q4",  q4, 4'b0010);
    end

    // Asynchronous reset midway between edges with toggles pending.
    t1 = 1'b1; t4 = 4'b1111;
    #2 rst = 1'b1;
    #1;
    check("async_q1",  {3'b000, q1},  4'b0000);
    check("async_qb1", {3'b000, qb1}, 4'b0001);
    check("async_q4",  q4, 4'b1010);
    repeat (2) begin
      @(negedge clk);
      check("rsthold_q1", {3'b000, q1}, 4'b0000);
      check("rsthold_q4", q4, 4'b1010);
    end
    rst = 1'b0; t1 = 1'b1; t4 = 4'b0011;
    @(negedge clk);
    check("postrst_q1", {3'b000, q1}, 4'b0001);
    check("postrst_q4", q4, 4'b1001);

    // Glitch on t between edges, low again at the edge.
    t1 = 1'b0; t4 = 4'b0000;
    #2 t1 = 1'b1; t4 = 4'b1111;
    #1 t1 = 1'b0; t4 = 4'b0000;
    @(negedge clk);
    check("glitch_q1", {3'b000, q1}, 4'b0001);
    check("glitch_q4", q4, 4'b1001);

    // Held toggle gives a half-rate square wave.
    t1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("square_q1", {3'b000, q1}, (k % 2 == 0) ? 4'b0000 : 4'b0001);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
